ctrl_aut: RTL

Multi-cycle control automaton that drives the single-cycle MIPS-subset datapath. It:
- consumes the datapath's `opcode`, `funct` and `zero` outputs;
- sequences each instruction through a fixed four-state cycle;
- produces every datapath control strobe: `load`, `write`, `rd_mux_s`, `op2_mux_s`, `alu_funct`, `branch_mux_s`.

It sits beside the datapath at CPU top level and owns the run/halt behaviour and the retired-instruction count.

---
 rtl/ctrl_aut_pkg.sv | 38 +++
 rtl/ctrl_decoder.sv | 50 +++++
 rtl/ctrl_aut.sv | 107 ++++++++++
 3 files changed

// File: rtl/ctrl_aut_pkg.sv
// Shared constants, FSM state encoding and control-word layout for the ctrl_aut controller.
package ctrl_aut_pkg;

    localparam int unsigned OpW = 6;
    localparam int unsigned FnW = 6;

    localparam logic [OpW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OpW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OpW-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OpW-1:0] OP_ORI   = 6'h0D;
    localparam logic [OpW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OpW-1:0] OP_BNE   = 6'h05;
    localparam logic [OpW-1:0] OP_HALT  = 6'h3F;

    localparam logic [FnW-1:0] FN_ADD = 6'h20;
    localparam logic [FnW-1:0] FN_SUB = 6'h22;
    localparam logic [FnW-1:0] FN_AND = 6'h24;
    localparam logic [FnW-1:0] FN_OR  = 6'h25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_COMMIT,
        ST_HALT
    } state_e;

    typedef struct packed {
        logic           write;
        logic           rd_mux_s;
        logic           op2_mux_s;
        logic [FnW-1:0] alu_funct;
        logic           br_eq;
        logic           br_ne;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct to control-word mapping, with valid and halt flags.
module ctrl_decoder
    import ctrl_aut_pkg::*;
(
    input  logic [OpW-1:0] i_opcode,
    input  logic [FnW-1:0] i_funct,
    output ctrl_word_t     o_cw,
    output logic           o_valid,
    output logic           o_halt
);

    always_comb begin
        o_cw    = '0;
        o_valid = 1'b1;
        o_halt  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_cw.write     = 1'b1;
                o_cw.rd_mux_s  = 1'b1;
                o_cw.alu_funct = i_funct;
            end
            OP_ADDI: begin
                o_cw.write     = 1'b1;
                o_cw.op2_mux_s = 1'b1;
                o_cw.alu_funct = FN_ADD;
            end
            OP_ANDI: begin
                o_cw.write     = 1'b1;
                o_cw.op2_mux_s = 1'b1;
                o_cw.alu_funct = FN_AND;
            end
            OP_ORI: begin
                o_cw.write     = 1'b1;
                o_cw.op2_mux_s = 1'b1;
                o_cw.alu_funct = FN_OR;
            end
            OP_BEQ: begin
                o_cw.alu_funct = FN_SUB;
                o_cw.br_eq     = 1'b1;
            end
            OP_BNE: begin
                o_cw.alu_funct = FN_SUB;
                o_cw.br_ne     = 1'b1;
            end
            OP_HALT: o_halt = 1'b1;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_aut.sv
// Four-state multi-cycle control automaton for the MIPS-subset datapath.
// Define CTRL_AUT_ILLEGAL_TRAP_EN to halt on unsupported opcodes instead of executing a NOP.
module ctrl_aut
    import ctrl_aut_pkg::*;
#(
    parameter int unsigned RetireWidth = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [OpW-1:0]         opcode,
    input  logic [FnW-1:0]         funct,
    input  logic                   zero,
    output logic                   load,
    output logic                   write,
    output logic                   rd_mux_s,
    output logic                   op2_mux_s,
    output logic [FnW-1:0]         alu_funct,
    output logic                   branch_mux_s,
    output logic                   halted,
    output logic                   illegal,
    output logic [RetireWidth-1:0] retired
);

    state_e                 r_state;
    state_e                 w_state_next;
    ctrl_word_t             r_cw;
    ctrl_word_t             w_cw;
    logic                   w_valid;
    logic                   w_halt;
    logic                   w_stop;
    logic                   w_taken;
    logic                   r_load;
    logic                   r_write;
    logic                   r_branch;
    logic                   r_halted;
    logic                   r_illegal;
    logic [RetireWidth-1:0] r_retired;

    ctrl_decoder u_dec (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_cw     (w_cw),
        .o_valid  (w_valid),
        .o_halt   (w_halt)
    );

`ifdef CTRL_AUT_ILLEGAL_TRAP_EN
    assign w_stop = w_halt | ~w_valid;
`else
    assign w_stop = w_halt;
`endif

    assign w_taken = (r_cw.br_eq & zero) | (r_cw.br_ne & ~zero);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (run) w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = w_stop ? ST_HALT : ST_EXEC;
            ST_EXEC:   w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_FETCH;
            ST_HALT:   w_state_next = ST_HALT;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Commit strobes are loaded on the EXEC->COMMIT edge so they are high exactly during COMMIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cw      <= '0;
            r_load    <= 1'b0;
            r_write   <= 1'b0;
            r_branch  <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_load   <= (r_state == ST_EXEC);
            r_write  <= (r_state == ST_EXEC) & r_cw.write;
            r_branch <= (r_state == ST_EXEC) & w_taken;
            if (r_state == ST_DECODE) begin
                r_cw      <= w_cw;
                r_halted  <= r_halted | w_stop;
                r_illegal <= r_illegal | ~w_valid;
            end
            if (r_state == ST_COMMIT) r_retired <= r_retired + RetireWidth'(1);
        end
    end

    assign load         = r_load;
    assign write        = r_write;
    assign branch_mux_s = r_branch;
    assign rd_mux_s     = r_cw.rd_mux_s;
    assign op2_mux_s    = r_cw.op2_mux_s;
    assign alu_funct    = r_cw.alu_funct;
    assign halted       = r_halted;
    assign illegal      = r_illegal;
    assign retired      = r_retired;

endmodule
